// File: rtl/dcalc_vector_dot_n.sv
// Sequential IEEE-754 single dot product over N elements, time-sharing one multiplier and one adder.
// Optional macro DCALC_DOT_NEGATE_EN adds a captured negate input that flips the result sign.

module fp_handshake (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic [31:0] z_calc
);
   typedef enum logic [1:0] {S_IN, S_CALC, S_OUT} hs_state_t;
   hs_state_t state, state_nx;
   logic have_a, have_b, take_a, take_b;

   assign input_a_ack  = (state == S_IN) && !have_a;
   assign input_b_ack  = (state == S_IN) && !have_b;
   assign take_a       = input_a_stb && input_a_ack;
   assign take_b       = input_b_stb && input_b_ack;
   assign output_z_stb = (state == S_OUT);

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IN;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IN:    if ((have_a || take_a) && (have_b || take_b)) state_nx = S_CALC;
         S_CALC:  state_nx = S_OUT;
         S_OUT:   if (output_z_ack) state_nx = S_IN;
         default: state_nx = S_IN;
      endcase
   end

   // Operands may arrive on different cycles; each side is held once taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         have_a   <= 1'b0;
         have_b   <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         output_z <= '0;
      end else begin
         if (take_a) op_a <= input_a;
         if (take_b) op_b <= input_b;
         if (state_nx == S_CALC) begin
            have_a <= 1'b0;
            have_b <= 1'b0;
         end else begin
            if (take_a) have_a <= 1'b1;
            if (take_b) have_b <= 1'b1;
         end
         if (state == S_CALC) output_z <= z_calc;
      end
   end
endmodule

module multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);
   logic [31:0] op_a, op_b, z_calc;
   logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rnd;
   logic [47:0] prod;
   logic [22:0] man;
   logic signed [9:0] exp_s;

   fp_handshake u_hs (.*);

   // Round-to-nearest-even; denormal inputs and underflow flush to signed zero.
   always_comb begin
      sgn    = op_a[31] ^ op_b[31];
      a_zero = (op_a[30:23] == 8'h00);
      b_zero = (op_b[30:23] == 8'h00);
      a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'h0);
      b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'h0);
      a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'h0);
      b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'h0);
      prod   = 48'({1'b1, op_a[22:0]}) * 48'({1'b1, op_b[22:0]});
      exp_s  = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - 10'sd127;
      if (prod[47]) begin
         man   = prod[46:24];
         rnd   = prod[23] && ((|prod[22:0]) || prod[24]);
         exp_s = exp_s + 10'sd1;
      end else begin
         man   = prod[45:23];
         rnd   = prod[22] && ((|prod[21:0]) || prod[23]);
      end
      if (rnd) begin
         if (&man) exp_s = exp_s + 10'sd1;
         man = man + 23'd1;
      end
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) z_calc = 32'h7FC00000;
      else if (a_inf || b_inf)                                        z_calc = {sgn, 8'hFF, 23'h0};
      else if (a_zero || b_zero || exp_s <= 10'sd0)                   z_calc = {sgn, 31'h0};
      else if (exp_s >= 10'sd255)                                     z_calc = {sgn, 8'hFF, 23'h0};
      else                                                            z_calc = {sgn, exp_s[7:0], man};
   end
endmodule

module adder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);
   logic [31:0] op_a, op_b, z_calc, big, sml;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rnd;
   logic [7:0]  d;
   logic [26:0] x_ext, y_ext, y_sh, mask, n;
   logic [27:0] s;
   logic [4:0]  lz;
   logic [22:0] man;
   logic signed [9:0] exp_s;

   fp_handshake u_hs (.*);

   // Three guard bits (guard, round, sticky) below the 24-bit significand.
   always_comb begin
      a_zero = (op_a[30:23] == 8'h00);
      b_zero = (op_b[30:23] == 8'h00);
      a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'h0);
      b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'h0);
      a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'h0);
      b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'h0);
      if (op_a[30:0] >= op_b[30:0]) begin big = op_a; sml = op_b; end
      else                          begin big = op_b; sml = op_a; end
      d     = big[30:23] - sml[30:23];
      x_ext = {1'b1, big[22:0], 3'b000};
      y_ext = {1'b1, sml[22:0], 3'b000};
      mask  = '0;
      if (d > 8'd26) y_sh = 27'd1;
      else begin
         mask = (27'd1 << d) - 27'd1;
         y_sh = (y_ext >> d) | {26'd0, |(y_ext & mask)};
      end
      if (big[31] == sml[31]) s = {1'b0, x_ext} + {1'b0, y_sh};
      else                    s = {1'b0, x_ext} - {1'b0, y_sh};
      lz = '0;
      for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
      exp_s = $signed({2'b00, big[30:23]});
      if (s[27]) begin
         n     = s[27:1] | {26'd0, s[0]};
         exp_s = exp_s + 10'sd1;
      end else begin
         n     = s[26:0] << lz;
         exp_s = exp_s - $signed({5'd0, lz});
      end
      man = n[25:3];
      rnd = n[2] && ((|n[1:0]) || n[3]);
      if (rnd) begin
         if (&man) exp_s = exp_s + 10'sd1;
         man = man + 23'd1;
      end
      if (a_nan || b_nan || (a_inf && b_inf && (op_a[31] != op_b[31]))) z_calc = 32'h7FC00000;
      else if (a_inf)             z_calc = op_a;
      else if (b_inf)             z_calc = op_b;
      else if (a_zero && b_zero)  z_calc = {op_a[31] & op_b[31], 31'h0};
      else if (a_zero)            z_calc = op_b;
      else if (b_zero)            z_calc = op_a;
      else if (s == 28'd0)        z_calc = 32'h0;
      else if (exp_s >= 10'sd255) z_calc = {big[31], 8'hFF, 23'h0};
      else if (exp_s <= 10'sd0)   z_calc = {big[31], 31'h0};
      else                        z_calc = {big[31], exp_s[7:0], man};
   end
endmodule

module dcalc_vector_dot_n #(
   parameter int N = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_stb,
   output logic            in_ack,
   input  logic [N*32-1:0] a_flat,
   input  logic [N*32-1:0] b_flat,
`ifdef DCALC_DOT_NEGATE_EN
   input  logic            negate,
`endif
   output logic [31:0]     result,
   output logic            out_stb,
   input  logic            out_ack,
   output logic            busy
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, NEXT, OUT} state_t;
   state_t state, state_nx;

   logic [N-1:0][31:0] a_r, b_r;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        acc, prod, mul_z, add_z;
   logic mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
   logic add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
   logic seen_a, seen_b, req_a, req_b, req_done, last, core_rst;
`ifdef DCALC_DOT_NEGATE_EN
   logic neg_r;
`endif

   assign core_rst = ~rst;
   assign last     = (idx == IDX_W'(N - 1));
   assign in_ack   = (state == IDLE) && rst;
   assign out_stb  = (state == OUT);
   assign busy     = (state != IDLE);
`ifdef DCALC_DOT_NEGATE_EN
   assign result   = out_stb ? {acc[31] ^ neg_r, acc[30:0]} : 32'h0;
`else
   assign result   = out_stb ? acc : 32'h0;
`endif

   multiplier u_mul (
      .clk(clk), .rst(core_rst),
      .input_a(a_r[idx]), .input_a_stb(mul_a_stb), .input_a_ack(mul_a_ack),
      .input_b(b_r[idx]), .input_b_stb(mul_b_stb), .input_b_ack(mul_b_ack),
      .output_z(mul_z), .output_z_stb(mul_z_stb), .output_z_ack(mul_z_ack)
   );

   adder u_add (
      .clk(clk), .rst(core_rst),
      .input_a(acc), .input_a_stb(add_a_stb), .input_a_ack(add_a_ack),
      .input_b(prod), .input_b_stb(add_b_stb), .input_b_ack(add_b_ack),
      .output_z(add_z), .output_z_stb(add_z_stb), .output_z_ack(add_z_ack)
   );

   // Request phase ends once both operand acks have been seen, in either order.
   always_comb begin
      req_a    = (state == MUL_REQ) ? mul_a_ack : add_a_ack;
      req_b    = (state == MUL_REQ) ? mul_b_ack : add_b_ack;
      req_done = (seen_a || req_a) && (seen_b || req_b);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;

   always_comb begin
      state_nx  = state;
      mul_a_stb = 1'b0;
      mul_b_stb = 1'b0;
      mul_z_ack = 1'b0;
      add_a_stb = 1'b0;
      add_b_stb = 1'b0;
      add_z_ack = 1'b0;
      case (state)
         IDLE:     if (in_stb && in_ack) state_nx = MUL_REQ;
         MUL_REQ:  begin
            mul_a_stb = 1'b1;
            mul_b_stb = 1'b1;
            if (req_done) state_nx = MUL_WAIT;
         end
         MUL_WAIT: if (mul_z_stb) begin
            mul_z_ack = 1'b1;
            state_nx  = (idx == '0) ? NEXT : ADD_REQ;
         end
         ADD_REQ:  begin
            add_a_stb = 1'b1;
            add_b_stb = 1'b1;
            if (req_done) state_nx = ADD_WAIT;
         end
         ADD_WAIT: if (add_z_stb) begin
            add_z_ack = 1'b1;
            state_nx  = NEXT;
         end
         NEXT:     state_nx = last ? OUT : MUL_REQ;
         OUT:      if (out_ack) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r    <= '0;
         b_r    <= '0;
         idx    <= '0;
         acc    <= '0;
         prod   <= '0;
         seen_a <= 1'b0;
         seen_b <= 1'b0;
`ifdef DCALC_DOT_NEGATE_EN
         neg_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_stb && in_ack) begin
               a_r <= a_flat;
               b_r <= b_flat;
               idx <= '0;
`ifdef DCALC_DOT_NEGATE_EN
               neg_r <= negate;
`endif
            end
            MUL_REQ, ADD_REQ: begin
               if (req_done) begin
                  seen_a <= 1'b0;
                  seen_b <= 1'b0;
               end else begin
                  if (req_a) seen_a <= 1'b1;
                  if (req_b) seen_b <= 1'b1;
               end
            end
            // First product seeds the accumulator directly so -0.0 survives.
            MUL_WAIT: if (mul_z_stb) begin
               prod <= mul_z;
               if (idx == '0) acc <= mul_z;
            end
            ADD_WAIT: if (add_z_stb) acc <= add_z;
            NEXT:     if (!last) idx <= idx + IDX_W'(1);
            default:  ;
         endcase
      end
   end
endmodule
